// File: rtl/turf_pkg.sv
// Shared defaults, colour codes and FSM states for the turf territory tally.
package turf_pkg;

    localparam int NUM_PLAYERS_DEF = 4;
    localparam int COLOUR_W_DEF    = 3;
    localparam int GRID_W_DEF      = 160;
    localparam int GRID_H_DEF      = 120;
    localparam int X_W_DEF         = 8;
    localparam int Y_W_DEF         = 7;

    localparam logic [2:0] BG_COLOUR_DEF = 3'b000;
    localparam logic [2:0] P1_COLOUR     = 3'b001;
    localparam logic [2:0] P2_COLOUR     = 3'b010;
    localparam logic [2:0] P3_COLOUR     = 3'b100;
    localparam logic [2:0] P4_COLOUR     = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_SORT,
        S_DONE
    } state_t;

    function automatic int cnt_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/turf_rank_sorter.sv
// Sequential bubble sort of player indices by descending count.
// One compare-swap per cycle; strict compare keeps ties in index order.
module turf_rank_sorter #(
    parameter int NUM_PLAYERS = 4,
    parameter int CNT_W       = 15,
    parameter int IDX_W       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_PLAYERS*CNT_W-1:0] counts,
    output logic [NUM_PLAYERS*IDX_W-1:0] rank,
    output logic                         done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PLAYERS - 2);

    logic [IDX_W-1:0] idx [NUM_PLAYERS];
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] pass;
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;
    logic             active;
    logic             swap;

    assign a    = idx[j];
    assign b    = idx[j + 1'b1];
    assign swap = counts[b*CNT_W +: CNT_W] > counts[a*CNT_W +: CNT_W];

    always_comb begin
        rank = '0;
        for (int k = 0; k < NUM_PLAYERS; k++)
            rank[k*IDX_W +: IDX_W] = idx[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PLAYERS; i++)
                idx[i] <= IDX_W'(i);
            j      <= '0;
            pass   <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                for (int i = 0; i < NUM_PLAYERS; i++)
                    idx[i] <= IDX_W'(i);
                j      <= '0;
                pass   <= '0;
                active <= 1'b1;
            end else if (active) begin
                if (swap) begin
                    idx[j]        <= b;
                    idx[j + 1'b1] <= a;
                end
                if (j == LAST) begin
                    j <= '0;
                    if (pass == LAST) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        pass <= pass + 1'b1;
                    end
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/turf_tally.sv
// End-of-game territory scorer: scan colour RAM, count per player, rank.
// TURF_CLEAR_EN: read-then-write-BG per pixel, clearing the RAM as it scans.
module turf_tally
    import turf_pkg::*;
#(
    parameter int NUM_PLAYERS = NUM_PLAYERS_DEF,
    parameter int COLOUR_W    = COLOUR_W_DEF,
    parameter int GRID_W      = GRID_W_DEF,
    parameter int GRID_H      = GRID_H_DEF,
    parameter int X_W         = X_W_DEF,
    parameter int Y_W         = Y_W_DEF,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(BG_COLOUR_DEF),
    parameter int CNT_W       = cnt_width(GRID_W, GRID_H),
    parameter int IDX_W       = $clog2(NUM_PLAYERS)
) (
    input  logic                            CLOCK_50,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [NUM_PLAYERS*COLOUR_W-1:0] player_colours,
    output logic [X_W+Y_W-1:0]              ram_addr,
    input  logic [COLOUR_W-1:0]             ram_rdata,
    output logic                            ram_wren,
    output logic [COLOUR_W-1:0]             ram_wdata,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_PLAYERS*CNT_W-1:0]    counts,
    output logic [NUM_PLAYERS*COLOUR_W-1:0] ranked_colours,
    output logic [IDX_W-1:0]                winner
);

    state_t                          state;
    logic [X_W-1:0]                  x;
    logic [Y_W-1:0]                  y;
    logic [CNT_W-1:0]                cnt [NUM_PLAYERS];
    logic [NUM_PLAYERS*IDX_W-1:0]    rank_idx;
    logic [NUM_PLAYERS*COLOUR_W-1:0] rank_col;
    logic                            sort_go;
    logic                            sort_done;
    logic                            take;
    logic                            hit;
    logic [IDX_W-1:0]                hit_idx;
    logic                            last;

    assign last      = (x == X_W'(GRID_W - 1)) && (y == Y_W'(GRID_H - 1));
    assign ram_addr  = {x, y};
    assign ram_wdata = BG_COLOUR;

`ifdef TURF_CLEAR_EN
    logic phase;
    assign ram_wren = (state == S_SCAN) && phase;
    assign take     = (state == S_SCAN) && phase;
    assign sort_go  = (state == S_SCAN) && phase && last;
`else
    logic pend;
    assign ram_wren = 1'b0;
    assign take     = pend;
    assign sort_go  = (state == S_DRAIN);
`endif

    // Descending scan so the lowest matching index wins duplicates.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (ram_rdata != BG_COLOUR &&
                ram_rdata == player_colours[i*COLOUR_W +: COLOUR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        counts   = '0;
        rank_col = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            counts[k*CNT_W +: CNT_W] = cnt[k];
            rank_col[k*COLOUR_W +: COLOUR_W] =
                player_colours[rank_idx[k*IDX_W +: IDX_W]*COLOUR_W +: COLOUR_W];
        end
    end

    turf_rank_sorter #(
        .NUM_PLAYERS(NUM_PLAYERS),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_sorter (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .start (sort_go),
        .counts(counts),
        .rank  (rank_idx),
        .done  (sort_done)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            x              <= '0;
            y              <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ranked_colours <= '0;
            winner         <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++)
                cnt[i] <= '0;
`ifdef TURF_CLEAR_EN
            phase <= 1'b0;
`else
            pend  <= 1'b0;
`endif
        end else begin
            if (take && hit)
                cnt[hit_idx] <= cnt[hit_idx] + 1'b1;
`ifndef TURF_CLEAR_EN
            pend <= 1'b0;
`endif
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_SCAN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        x     <= '0;
                        y     <= '0;
                        for (int i = 0; i < NUM_PLAYERS; i++)
                            cnt[i] <= '0;
`ifdef TURF_CLEAR_EN
                        phase <= 1'b0;
`endif
                    end
                end
                S_SCAN: begin
`ifdef TURF_CLEAR_EN
                    phase <= ~phase;
                    if (phase) begin
`else
                    pend <= 1'b1;
                    begin
`endif
                        // Hold on the last pixel so no out-of-grid address appears.
                        if (last) begin
`ifdef TURF_CLEAR_EN
                            state <= S_SORT;
`else
                            state <= S_DRAIN;
`endif
                        end else if (y == Y_W'(GRID_H - 1)) begin
                            y <= '0;
                            x <= x + 1'b1;
                        end else begin
                            y <= y + 1'b1;
                        end
                    end
                end
                S_DRAIN: state <= S_SORT;
                S_SORT: begin
                    if (sort_done) begin
                        state          <= S_DONE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        ranked_colours <= rank_col;
                        winner         <= rank_idx[IDX_W-1:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turf_tally.sv
// Directed/randomised bench for turf_tally against a counting/ranking model.
module tb_turf_tally;
    import turf_pkg::*;

    localparam int N    = 4;
    localparam int CW   = 3;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CNTW = 15;
    localparam int IW   = 2;
    localparam int AW   = XW + YW;
`ifdef TURF_CLEAR_EN
    localparam int LAT = 2 * W * H + (N - 1) * (N - 1) + 1;
`else
    localparam int LAT = W * H + 1 + (N - 1) * (N - 1) + 1;
`endif

    logic            clk    = 1'b0;
    logic            resetn = 1'b0;
    logic            start  = 1'b0;
    logic [N*CW-1:0] pcol;
    logic [AW-1:0]   ram_addr;
    logic [CW-1:0]   ram_rdata;
    logic            ram_wren;
    logic [CW-1:0]   ram_wdata;
    logic            busy;
    logic            done;
    logic [N*CNTW-1:0] counts;
    logic [N*CW-1:0] ranked;
    logic [IW-1:0]   winner;

    logic [CW-1:0] mem     [0:(1<<AW)-1];
    bit            written [0:(1<<AW)-1];
    int            checks   = 0;
    int            errors   = 0;
    int            bad_addr = 0;
    int            exp_cnt  [N];
    int            exp_rank [N];

    turf_tally dut (
        .CLOCK_50      (clk),
        .resetn        (resetn),
        .start         (start),
        .player_colours(pcol),
        .ram_addr      (ram_addr),
        .ram_rdata     (ram_rdata),
        .ram_wren      (ram_wren),
        .ram_wdata     (ram_wdata),
        .busy          (busy),
        .done          (done),
        .counts        (counts),
        .ranked_colours(ranked),
        .winner        (winner)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_wren) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        if (ram_addr[YW-1:0] >= YW'(H) || ram_addr[AW-1:YW] >= XW'(W))
            bad_addr <= bad_addr + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int addr_of(input int x, input int y);
        return x * (1 << YW) + y;
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a]     = '0;
            written[a] = 1'b0;
        end
    endtask

    task automatic fill(input logic [CW-1:0] c, input int n);
        int x;
        int y;
        repeat (n) begin
            do begin
                x = $urandom_range(0, W - 1);
                y = $urandom_range(0, H - 1);
            end while (mem[addr_of(x, y)] != '0);
            mem[addr_of(x, y)] = c;
        end
    endtask

    // Count by first matching player, then pick ranks by repeated max search.
    task automatic model();
        bit used [N];
        int best;
        logic [CW-1:0] c;
        for (int i = 0; i < N; i++) begin
            exp_cnt[i] = 0;
            used[i]    = 1'b0;
        end
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++) begin
                c = mem[addr_of(x, y)];
                for (int i = 0; i < N; i++)
                    if (c != '0 && c == pcol[i*CW +: CW]) begin
                        exp_cnt[i]++;
                        break;
                    end
            end
        for (int k = 0; k < N; k++) begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (!used[i] && (best < 0 || exp_cnt[i] > exp_cnt[best]))
                    best = i;
            exp_rank[k] = best;
            used[best]  = 1'b1;
        end
    endtask

    task automatic check_results(input string tag);
        logic [N*CW-1:0] er;
        er = '0;
        for (int i = 0; i < N; i++)
            chk($sformatf("%s cnt%0d", tag, i), counts[i*CNTW +: CNTW], exp_cnt[i]);
        for (int k = 0; k < N; k++)
            er[k*CW +: CW] = pcol[exp_rank[k]*CW +: CW];
        chk({tag, " ranked"}, ranked, er);
        chk({tag, " winner"}, winner, exp_rank[0]);
        chk({tag, " busy_end"}, busy, 0);
    endtask

    task automatic run(input string tag, input int pulse_at);
        int n;
        n = 0;
        model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_go"}, busy, 1);
        chk({tag, " done_drop"}, done, 0);
        while (!done && n < 2 * LAT) begin
            @(negedge clk);
            n++;
            start = (n == pulse_at);
        end
        start = 1'b0;
        chk({tag, " latency"}, n, LAT);
        check_results(tag);
    endtask

    initial begin
        pcol = {P4_COLOUR, P3_COLOUR, P2_COLOUR, P1_COLOUR};
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst counts", counts, 0);
        chk("rst ranked", ranked, 0);
        chk("rst winner", winner, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst addr", ram_addr, 0);
        chk("rst wren", ram_wren, 0);
        resetn = 1'b1;

`ifdef TURF_CLEAR_EN
        fill(P2_COLOUR, 20);
        run("clr", -1);
        chk("clr p2", counts[CNTW +: CNTW], 20);
        begin
            int nz;
            int nw;
            nz = 0;
            nw = 0;
            for (int x = 0; x < W; x++)
                for (int y = 0; y < H; y++) begin
                    if (mem[addr_of(x, y)] != '0) nz++;
                    if (written[addr_of(x, y)]) nw++;
                end
            chk("clr nonzero", nz, 0);
            chk("clr written", nw, W * H);
        end
        run("rerun", -1);
        chk("rerun counts", counts, 0);
`else
        run("bg", -1);
        chk("bg ranked_id", ranked, pcol);

        fill(P1_COLOUR, 50);
        fill(P2_COLOUR, 50);
        fill(P3_COLOUR, 100);
        fill(P4_COLOUR, 10);
        mem[addr_of(0, 3)] = P1_COLOUR;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst counts", counts, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst done", done, 0);
        chk("mid_rst addr", ram_addr, 0);
        chk("mid_rst ranked", ranked, 0);
        @(negedge clk);
        resetn = 1'b1;

        mem[addr_of(0, 3)] = '0;
        run("pat", -1);
        chk("pat ranked_k", ranked, {P4_COLOUR, P2_COLOUR, P1_COLOUR, P3_COLOUR});
        chk("pat winner_k", winner, 2);

        clear_mem();
        mem[addr_of(W - 1, H - 1)] = P4_COLOUR;
        mem[addr_of(0, 0)]         = P1_COLOUR;
        run("corner", 5000);
        chk("corner p1", counts[0 +: CNTW], 1);
        chk("corner p4", counts[3*CNTW +: CNTW], 1);

        for (int i = 0; i < N; i++)
            pcol[i*CW +: CW] = CW'($urandom_range(1, 7));
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                mem[addr_of(x, y)] = CW'($urandom_range(0, 7));
        run("rand", -1);
`endif
        chk("addr range", bad_addr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
